// File: rtl/iter_divider_pkg.sv
// ---------------------------------------------------------------------------
// iter_divider_pkg
// Shared definitions for the iterative restoring divider that serves the
// MIPS DIV/DIVU instructions.
//   - divState_t    : FSM state encoding (IDLE, CALC, FIXUP, DONE)
//   - DIV_WIDTH     : default operand width
//   - DIV_CNT_W     : iteration counter width for the default operand width
//   - DIV_ZERO_QUOT : quotient reported for a divide by zero (all ones)
//   - cntWidth()    : counter width for an arbitrary operand width
// ---------------------------------------------------------------------------
package iter_divider_pkg;

   // The encoding is fixed so state values can be recognised directly on a
   // debug bus without any decode table.
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      FIXUP = 2'd2,
      DONE  = 2'd3
   } divState_t;

   localparam int DIV_WIDTH = 32;

   // The counter only has to reach WIDTH-1, so $clog2(WIDTH) bits are enough.
   // The floor of one bit keeps the counter vector legal for tiny widths.
   function automatic int cntWidth(input int width);
      return (width <= 2) ? 1 : $clog2(width);
   endfunction

   localparam int DIV_CNT_W = cntWidth(DIV_WIDTH);

   localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOT = '1;

endpackage : iter_divider_pkg

// File: rtl/iter_divider_if.sv
// ---------------------------------------------------------------------------
// iter_divider_if
// Groups the request and result signals between the control unit and the
// divider.
//   master : control unit side. It drives start, is_signed, dividend and
//            divisor, and it observes busy, done and the results.
//   slave  : divider side. It is the mirror image of master.
// Signals:
//   start, is_signed        request and operation type (DIV = 1, DIVU = 0)
//   dividend, divisor       operands, sampled together with start
//   busy, done              stall indication and one-cycle result strobe
//   quotient, remainder     LO and HI results
//   div_by_zero             flag for the last operation
// ---------------------------------------------------------------------------
interface iter_divider_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] quotient;
   logic [WIDTH-1:0] remainder;
   logic             div_by_zero;

   modport master (
      output start, is_signed, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, is_signed, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );

endinterface : iter_divider_if

// File: rtl/iter_divider_div_step.sv
// ---------------------------------------------------------------------------
// div_step
// One combinational iteration of a restoring divider. The pair
// {partial remainder, quotient register} is shifted left by one bit. The
// divisor magnitude is then trial-subtracted from the shifted remainder. The
// difference is kept only when it is not negative.
// Ports:
//   i_partRem  : current partial remainder
//   i_quot     : current quotient register; its MSB feeds the remainder
//   i_divMag   : divisor magnitude
//   o_nextRem  : partial remainder after this iteration
//   o_nextQuot : quotient register with the new quotient bit in the LSB
// ---------------------------------------------------------------------------
module div_step #(
   parameter int WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_partRem,
   input  logic [WIDTH-1:0] i_quot,
   input  logic [WIDTH-1:0] i_divMag,
   output logic [WIDTH-1:0] o_nextRem,
   output logic [WIDTH-1:0] o_nextQuot
);

   logic [WIDTH:0] wShifted;
   logic [WIDTH:0] wTrial;

   // The partial remainder is always below the divisor magnitude, so the
   // shifted value stays below 2^(WIDTH+1). The subtraction therefore fits
   // in WIDTH+1 bits. A set MSB on the difference means the trial went
   // negative. When that happens the shifted value itself is below the
   // divisor, so restoring it loses no bits.
   assign wShifted = {i_partRem, i_quot[WIDTH-1]};
   assign wTrial   = wShifted - {1'b0, i_divMag};

   // Keep the trial result when it is non-negative and shift in a quotient
   // one. Otherwise restore the shifted remainder and shift in a zero.
   assign o_nextRem  = wTrial[WIDTH] ? wShifted[WIDTH-1:0] : wTrial[WIDTH-1:0];
   assign o_nextQuot = {i_quot[WIDTH-2:0], ~wTrial[WIDTH]};

endmodule : div_step

// File: rtl/iter_divider.sv
// ---------------------------------------------------------------------------
// iter_divider
// Multi-cycle restoring divider for the MIPS DIV/DIVU instructions. It
// produces HI = remainder and LO = quotient. The divider works on operand
// magnitudes for WIDTH cycles. It then applies the result signs in a single
// FIXUP cycle and strobes done for one cycle.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset; it aborts any operation in flight
//   bus   : slave side of iter_divider_if. It carries start, is_signed,
//           dividend and divisor in. It carries busy, done, quotient,
//           remainder and div_by_zero out.
// ---------------------------------------------------------------------------
module iter_divider
   import iter_divider_pkg::*;
#(
   parameter int WIDTH = DIV_WIDTH
) (
   input  logic           clk,
   input  logic           rst_n,
   iter_divider_if.slave  bus
);

   localparam int             CNT_W    = cntWidth(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   divState_t        rState;
   divState_t        wNextState;
   logic [CNT_W-1:0] rCount;
   logic [WIDTH-1:0] rPartRem;
   logic [WIDTH-1:0] rQuot;
   logic [WIDTH-1:0] rDivMag;
   logic             rNegQ;
   logic             rNegR;
   logic [WIDTH-1:0] rQuotient;
   logic [WIDTH-1:0] rRemainder;
   logic             rDivZero;

   logic             wAccept;
   logic             wDivisorZero;
   logic             wLastIter;
   logic [WIDTH-1:0] wDividendMag;
   logic [WIDTH-1:0] wDivisorMag;
   logic [WIDTH-1:0] wNextRem;
   logic [WIDTH-1:0] wNextQuot;

   // A request is honoured only in IDLE. A start in any other state is
   // dropped rather than queued, because the control unit is still stalled
   // on busy at that point.
   assign wAccept      = (rState == IDLE) && bus.start;
   assign wDivisorZero = (bus.divisor == '0);
   assign wLastIter    = (rCount == LAST_CNT);

   // The iteration runs on magnitudes only. For DIV, a negative operand is
   // converted to its magnitude. The most negative value maps to itself,
   // and that value read as unsigned is exactly its magnitude.
   assign wDividendMag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
   assign wDivisorMag  = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;

   div_step #(
      .WIDTH(WIDTH)
   ) u_divStep (
      .i_partRem (rPartRem),
      .i_quot    (rQuot),
      .i_divMag  (rDivMag),
      .o_nextRem (wNextRem),
      .o_nextQuot(wNextQuot)
   );

   // State register. Reset returns to IDLE at once, so an operation in
   // flight never reaches DONE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rState <= IDLE;
      end else begin
         rState <= wNextState;
      end
   end

   // Next-state logic. A zero divisor skips the iterations and goes straight
   // to DONE, so that case is reported one cycle after start.
   always_comb begin
      wNextState = rState;
      unique case (rState)
         IDLE: begin
            if (bus.start) begin
               wNextState = wDivisorZero ? DONE : CALC;
            end
         end
         CALC: begin
            if (wLastIter) begin
               wNextState = FIXUP;
            end
         end
         FIXUP:   wNextState = DONE;
         DONE:    wNextState = IDLE;
         default: wNextState = IDLE;
      endcase
   end

   // Working registers. On an accepted request the dividend magnitude is
   // loaded into the quotient register. The iterations shift it out through
   // the partial remainder while the quotient bits shift in behind it. The
   // operand ports are ignored once CALC has started.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rCount   <= '0;
         rPartRem <= '0;
         rQuot    <= '0;
         rDivMag  <= '0;
         rNegQ    <= 1'b0;
         rNegR    <= 1'b0;
      end else if (wAccept && !wDivisorZero) begin
         rCount   <= '0;
         rPartRem <= '0;
         rQuot    <= wDividendMag;
         rDivMag  <= wDivisorMag;
         rNegQ    <= bus.is_signed & (bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1]);
         rNegR    <= bus.is_signed & bus.dividend[WIDTH-1];
      end else if (rState == CALC) begin
         rPartRem <= wNextRem;
         rQuot    <= wNextQuot;
         rCount   <= wLastIter ? '0 : rCount + 1'b1;
      end
   end

   // Result registers. They change only in FIXUP or on a divide by zero, and
   // they hold their values otherwise. The remainder takes the sign of the
   // dividend. The quotient is negative when the operand signs differ.
   // Overflow of the most negative value divided by -1 wraps silently, the
   // same way MIPS does.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rQuotient  <= '0;
         rRemainder <= '0;
         rDivZero   <= 1'b0;
      end else if (wAccept && wDivisorZero) begin
         rQuotient  <= {WIDTH{1'b1}};
         rRemainder <= bus.dividend;
         rDivZero   <= 1'b1;
      end else if (rState == FIXUP) begin
         rQuotient  <= rNegQ ? -rQuot : rQuot;
         rRemainder <= rNegR ? -rPartRem : rPartRem;
         rDivZero   <= 1'b0;
      end
   end

   // Status outputs decode directly from the state register. This makes done
   // a clean one-cycle pulse and keeps busy high across CALC and FIXUP.
   assign bus.busy        = (rState == CALC) || (rState == FIXUP);
   assign bus.done        = (rState == DONE);
   assign bus.quotient    = rQuotient;
   assign bus.remainder   = rRemainder;
   assign bus.div_by_zero = rDivZero;

endmodule : iter_divider

// File: tb/tb_iter_divider.sv
// ---------------------------------------------------------------------------
// tb_iter_divider
// Directed testbench for iter_divider with WIDTH = 32. Each vector has a
// hand-computed quotient and remainder. Every check goes through
// checkOutput.
// ---------------------------------------------------------------------------
module tb_iter_divider;

   logic clk;
   logic rst_n;
   int   testCount;
   int   failCount;

   iter_divider_if #(.WIDTH(32)) bus ();

   iter_divider #(
      .WIDTH(32)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   // Free-running clock with a 10 time-unit period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Counts one comparison and reports it if the values differ.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      testCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issues one request in the current cycle (cycle 0). It then scrambles the
   // operands while the divider works and waits a bounded number of cycles
   // for done. If injectCyc is non-zero, a second start with different
   // operands is raised in that cycle, and the divider must ignore it. The
   // task returns in the first IDLE cycle after done, after checking that
   // done has dropped.
   task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                input int injectCyc, output int doneCyc, output int busyCnt,
                                output logic [31:0] q, output logic [31:0] r, output logic dz);
      int cyc;
      bus.start     = 1'b1;
      bus.is_signed = sgn;
      bus.dividend  = a;
      bus.divisor   = b;
      cyc     = 0;
      busyCnt = 0;
      doneCyc = -1;
      q  = '0;
      r  = '0;
      dz = 1'b0;
      while (cyc < 100 && doneCyc < 0) begin
         tick();
         cyc++;
         if (cyc == injectCyc) begin
            bus.start     = 1'b1;
            bus.is_signed = 1'b0;
            bus.dividend  = 32'd200;
            bus.divisor   = 32'd3;
         end else begin
            bus.start     = 1'b0;
            bus.is_signed = ~sgn;
            bus.dividend  = 32'hDEADBEEF;
            bus.divisor   = 32'h00000001;
         end
         if (bus.busy) busyCnt++;
         if (bus.done) begin
            doneCyc = cyc;
            q  = bus.quotient;
            r  = bus.remainder;
            dz = bus.div_by_zero;
         end
      end
      bus.start = 1'b0;
      tick();
      checkOutput("donePulseWidth", {31'd0, bus.done}, 32'd0);
   endtask

   // Runs one full division and checks its latency, busy span and results.
   task automatic runCheck(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] expQ, input logic [31:0] expR,
                           input int injectCyc);
      int doneCyc, busyCnt;
      logic [31:0] q, r;
      logic dz;
      applyStimulus(sgn, a, b, injectCyc, doneCyc, busyCnt, q, r, dz);
      checkOutput({tag, ".doneCycle"}, doneCyc, 32'd34);
      checkOutput({tag, ".busyCycles"}, busyCnt, 32'd33);
      checkOutput({tag, ".quotient"}, q, expQ);
      checkOutput({tag, ".remainder"}, r, expR);
      checkOutput({tag, ".divByZero"}, {31'd0, dz}, 32'd0);
   endtask

   initial begin
      int doneCyc, busyCnt;
      logic [31:0] q, r;
      logic dz;
      testCount     = 0;
      failCount     = 0;
      rst_n         = 1'b0;
      bus.start     = 1'b0;
      bus.is_signed = 1'b0;
      bus.dividend  = '0;
      bus.divisor   = '0;

      // Reset state
      repeat (2) tick();
      checkOutput("reset.busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("reset.done", {31'd0, bus.done}, 32'd0);
      checkOutput("reset.quotient", bus.quotient, 32'd0);
      checkOutput("reset.remainder", bus.remainder, 32'd0);
      checkOutput("reset.divByZero", {31'd0, bus.div_by_zero}, 32'd0);
      rst_n = 1'b1;
      tick();

      // Main function: unsigned, signed, edge values
      runCheck("divu100by7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
      runCheck("divNeg100by7", 1'b1, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2, 32'hFFFFFFFE, 0);
      runCheck("div100byNeg7", 1'b1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 0);
      runCheck("divNeg100byNeg7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0);
      runCheck("divuMaxBy1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0);
      runCheck("divOverflow", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
      runCheck("divu5by9", 1'b0, 32'd5, 32'd9, 32'd0, 32'd5, 0);

      // Divide by zero, then a normal divide that clears the flag
      applyStimulus(1'b0, 32'd1234, 32'd0, 0, doneCyc, busyCnt, q, r, dz);
      checkOutput("divZero.doneCycle", doneCyc, 32'd1);
      checkOutput("divZero.busyCycles", busyCnt, 32'd0);
      checkOutput("divZero.quotient", q, 32'hFFFFFFFF);
      checkOutput("divZero.remainder", r, 32'd1234);
      checkOutput("divZero.flag", {31'd0, dz}, 32'd1);
      checkOutput("divZero.holdQuotient", bus.quotient, 32'hFFFFFFFF);
      runCheck("divu10by3AfterZero", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 0);

      // Protocol: a start raised during CALC with new operands is ignored
      runCheck("ignoredStart", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 5);

      // Back-to-back: each run begins in the first IDLE cycle after DONE
      runCheck("backToBackA", 1'b0, 32'd1000, 32'd10, 32'd100, 32'd0, 0);
      runCheck("backToBackB", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);

      // Reset mid-operation: outputs clear immediately and no done appears
      bus.start     = 1'b1;
      bus.is_signed = 1'b0;
      bus.dividend  = 32'd500;
      bus.divisor   = 32'd7;
      for (int c = 1; c <= 10; c++) begin
         tick();
         bus.start = 1'b0;
      end
      checkOutput("midReset.busyBefore", {31'd0, bus.busy}, 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midReset.busy", {31'd0, bus.busy}, 32'd0);
      checkOutput("midReset.done", {31'd0, bus.done}, 32'd0);
      checkOutput("midReset.quotient", bus.quotient, 32'd0);
      checkOutput("midReset.remainder", bus.remainder, 32'd0);
      checkOutput("midReset.divByZero", {31'd0, bus.div_by_zero}, 32'd0);
      for (int c = 0; c < 3; c++) begin
         tick();
         checkOutput("midReset.noDone", {31'd0, bus.done}, 32'd0);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 40; c++) begin
         tick();
         checkOutput("afterReset.idle", {30'd0, bus.busy, bus.done}, 32'd0);
      end
      runCheck("afterReset10by3", 1'b0, 32'd10, 32'd3, 32'd3, 32'd1, 0);

      $display("[TB] %0d tests run, %0d failed", testCount, failCount);
      $finish;
   end

endmodule : tb_iter_divider
